// File: rtl/prbs_pkg.sv
// Shared PRBS9 constants and checker state encoding.
// Used by both the PRBS9 checker and the matching generator.
package prbs_pkg;

    localparam int PRBS_W = 9;
    localparam int TAP_HI = 8;
    localparam int TAP_LO = 4;

    localparam logic [PRBS_W-1:0] PRBS_SEED = 9'b110101010;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/prbs9_predict.sv
// PRBS9 (x^9+x^5+1) next-bit function.
// sr_i[0] is the newest bit; shared by generator and checker.
module prbs9_predict
    import prbs_pkg::*;
(
    input  logic [PRBS_W-1:0] sr_i,
    output logic              pred_o
);

    assign pred_o = sr_i[TAP_HI] ^ sr_i[TAP_LO];

endmodule

// File: rtl/prbs9_checker.sv
// PRBS9 checker: FILL/SEARCH/LOCKED with windowed loss of lock.
// Define PRBS_CHK_SAT_EN to make the statistics counters saturate.
module prbs9_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_THR = 8,
    parameter int LOSS_WIN = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_lock,
    output logic             o_err,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [CNT_W-1:0] o_err_count
);

    localparam int MW = $clog2(LOCK_CNT + PRBS_W) + 1;
    localparam int BW = $clog2(LOSS_WIN + 1);
    localparam int EW = $clog2(LOSS_THR + 1);

    state_e            state_q, state_d;
    logic [PRBS_W-1:0] sr_q, sr_d;
    logic [MW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     wbit_q, wbit_d;
    logic [EW-1:0]     werr_q, werr_d;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;
    logic [CNT_W-1:0]  ecnt_q, ecnt_d;
    logic              err_q, err_d;
    logic              pred;
    logic              mis;

    function automatic logic [CNT_W-1:0] bump(
        input logic [CNT_W-1:0] v
    );
`ifdef PRBS_CHK_SAT_EN
        return (&v) ? v : v + CNT_W'(1);
`else
        return v + CNT_W'(1);
`endif
    endfunction

    prbs9_predict u_pred (
        .sr_i   (sr_q),
        .pred_o (pred)
    );

    // Next-state: fill, search for a consistent stream, then free-run
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        wbit_d  = wbit_q;
        werr_d  = werr_q;
        bcnt_d  = bcnt_q;
        ecnt_d  = ecnt_q;
        err_d   = 1'b0;
        mis     = 1'b0;
        if (i_valid) begin
            unique case (state_q)
                ST_FILL: begin
                    sr_d = {sr_q[PRBS_W-2:0], i_bit};
                    if (cnt_q == MW'(PRBS_W - 1)) begin
                        state_d = ST_SEARCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + MW'(1);
                    end
                end
                ST_SEARCH: begin
                    sr_d = {sr_q[PRBS_W-2:0], i_bit};
                    // an all-zero register predicts zeros forever
                    if (i_bit == pred && sr_q != '0) begin
                        if (cnt_q == MW'(LOCK_CNT - 1)) begin
                            state_d = ST_LOCKED;
                            cnt_d   = '0;
                            wbit_d  = '0;
                            werr_d  = '0;
                        end else begin
                            cnt_d = cnt_q + MW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    sr_d   = {sr_q[PRBS_W-2:0], pred};
                    mis    = i_bit ^ pred;
                    err_d  = mis;
                    bcnt_d = bump(bcnt_q);
                    if (mis) begin
                        ecnt_d = bump(ecnt_q);
                    end
                    if (mis && werr_q == EW'(LOSS_THR - 1)) begin
                        state_d = ST_FILL;
                        cnt_d   = '0;
                        wbit_d  = '0;
                        werr_d  = '0;
                    end else if (wbit_q == BW'(LOSS_WIN - 1)) begin
                        wbit_d = '0;
                        werr_d = '0;
                    end else begin
                        wbit_d = wbit_q + BW'(1);
                        werr_d = werr_q + EW'(mis);
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end
            endcase
        end
        if (i_clear) begin
            bcnt_d = '0;
            ecnt_d = '0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state_q <= ST_FILL;
            sr_q    <= '0;
            cnt_q   <= '0;
            wbit_q  <= '0;
            werr_q  <= '0;
            bcnt_q  <= '0;
            ecnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            wbit_q  <= wbit_d;
            werr_q  <= werr_d;
            bcnt_q  <= bcnt_d;
            ecnt_q  <= ecnt_d;
            err_q   <= err_d;
        end
    end

    assign o_lock      = (state_q == ST_LOCKED);
    assign o_err       = err_q;
    assign o_bit_count = bcnt_q;
    assign o_err_count = ecnt_q;

endmodule

// File: tb/tb_prbs9_checker.sv
// Directed bench for prbs9_checker: lock, errors, loss, stuck input,
// gapped strobe, clear/reset priority.
module tb_prbs9_checker;

    logic        clk;
    logic        i_reset;
    logic        i_valid;
    logic        i_bit;
    logic        i_clear;
    logic        o_lock;
    logic        o_err;
    logic [31:0] o_bit_count;
    logic [31:0] o_err_count;

    int          checks;
    int          failures;
    logic [8:0]  g;

    prbs9_checker dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_bit       (i_bit),
        .i_clear     (i_clear),
        .o_lock      (o_lock),
        .o_err       (o_err),
        .o_bit_count (o_bit_count),
        .o_err_count (o_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference generator: x^9+x^5+1, newest bit in g[0]
    task automatic gen(output logic b);
        b = g[4] ^ g[8];
        g = {g[7:0], b};
    endtask

    task automatic step(input logic v, input logic b, input logic c);
        i_valid = v;
        i_bit   = b;
        i_clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        i_reset = 1'b1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (o_lock !== 1'b0) begin
            failures++;
            $display("FAIL reset_lock got=%0b exp=0", o_lock);
        end
        checks++;
        if (o_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%0b exp=0", o_err);
        end
        checks++;
        if (o_bit_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_bitcnt got=%0d exp=0", o_bit_count);
        end
        checks++;
        if (o_err_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_errcnt got=%0d exp=0", o_err_count);
        end
        i_reset = 1'b1;
    endtask

    task automatic test_lock();
        logic b;
        int   p;
        do_reset();
        g = 9'b110101010;
        for (int i = 1; i <= 24; i++) begin
            gen(b);
            step(1'b1, b, 1'b0);
        end
        checks++;
        if (o_lock !== 1'b0) begin
            failures++;
            $display("FAIL lock_early got=%0b exp=0", o_lock);
        end
        gen(b);
        step(1'b1, b, 1'b0);
        checks++;
        if (o_lock !== 1'b1) begin
            failures++;
            $display("FAIL lock_bit25 got=%0b exp=1", o_lock);
        end
        p = 0;
        for (int i = 1; i <= 1000; i++) begin
            gen(b);
            step(1'b1, b, 1'b0);
            p += int'(o_err);
        end
        checks++;
        if (p != 0) begin
            failures++;
            $display("FAIL lock_pulses got=%0d exp=0", p);
        end
        checks++;
        if (o_err_count !== 32'd0) begin
            failures++;
            $display("FAIL lock_errcnt got=%0d exp=0", o_err_count);
        end
        checks++;
        if (o_bit_count !== 32'd1000) begin
            failures++;
            $display("FAIL lock_bitcnt got=%0d exp=1000", o_bit_count);
        end
    endtask

    task automatic test_single_error();
        logic b;
        int   p;
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (o_bit_count !== 32'd0) begin
            failures++;
            $display("FAIL clear_idle got=%0d exp=0", o_bit_count);
        end
        p = 0;
        for (int i = 1; i <= 1000; i++) begin
            gen(b);
            step(1'b1, (i == 100) ? ~b : b, 1'b0);
            if (i == 100) begin
                checks++;
                if (o_err !== 1'b1) begin
                    failures++;
                    $display("FAIL err_pulse got=%0b exp=1", o_err);
                end
            end
            p += int'(o_err);
        end
        checks++;
        if (p != 1) begin
            failures++;
            $display("FAIL single_pulses got=%0d exp=1", p);
        end
        checks++;
        if (o_err_count !== 32'd1) begin
            failures++;
            $display("FAIL single_errcnt got=%0d exp=1", o_err_count);
        end
        checks++;
        if (o_bit_count !== 32'd1000) begin
            failures++;
            $display("FAIL single_bitcnt got=%0d exp=1000", o_bit_count);
        end
        checks++;
        if (o_lock !== 1'b1) begin
            failures++;
            $display("FAIL single_lock got=%0b exp=1", o_lock);
        end
    endtask

    task automatic test_loss();
        logic b;
        for (int i = 1; i <= 8; i++) begin
            gen(b);
            step(1'b1, ~b, 1'b0);
            if (i == 7) begin
                checks++;
                if (o_lock !== 1'b1) begin
                    failures++;
                    $display("FAIL loss_7th got=%0b exp=1", o_lock);
                end
            end
        end
        checks++;
        if (o_lock !== 1'b0) begin
            failures++;
            $display("FAIL loss_8th got=%0b exp=0", o_lock);
        end
        checks++;
        if (o_err !== 1'b1) begin
            failures++;
            $display("FAIL loss_err got=%0b exp=1", o_err);
        end
        for (int i = 1; i <= 24; i++) begin
            gen(b);
            step(1'b1, b, 1'b0);
        end
        checks++;
        if (o_lock !== 1'b0) begin
            failures++;
            $display("FAIL relock_early got=%0b exp=0", o_lock);
        end
        gen(b);
        step(1'b1, b, 1'b0);
        checks++;
        if (o_lock !== 1'b1) begin
            failures++;
            $display("FAIL relock_25 got=%0b exp=1", o_lock);
        end
    endtask

    task automatic test_stuck0();
        logic seen;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step(1'b1, 1'b0, 1'b0);
            seen |= o_lock;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL stuck0_lock got=%0b exp=0", seen);
        end
    endtask

    task automatic test_gapped();
        logic b;
        int   p;
        do_reset();
        g = 9'b110101010;
        for (int i = 1; i <= 24; i++) begin
            gen(b);
            step(1'b1, b, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (o_lock !== 1'b0) begin
            failures++;
            $display("FAIL gap_early got=%0b exp=0", o_lock);
        end
        gen(b);
        step(1'b1, b, 1'b0);
        checks++;
        if (o_lock !== 1'b1) begin
            failures++;
            $display("FAIL gap_lock got=%0b exp=1", o_lock);
        end
        p = 0;
        for (int i = 1; i <= 100; i++) begin
            step(1'b0, 1'b1, 1'b0);
            p += int'(o_err);
            step(1'b0, 1'b0, 1'b0);
            p += int'(o_err);
            gen(b);
            step(1'b1, b, 1'b0);
            p += int'(o_err);
        end
        checks++;
        if (p != 0) begin
            failures++;
            $display("FAIL gap_pulses got=%0d exp=0", p);
        end
        checks++;
        if (o_bit_count !== 32'd100) begin
            failures++;
            $display("FAIL gap_bitcnt got=%0d exp=100", o_bit_count);
        end
    endtask

    task automatic test_clear_reset();
        logic b;
        gen(b);
        step(1'b1, ~b, 1'b1);
        checks++;
        if (o_err !== 1'b1) begin
            failures++;
            $display("FAIL clr_err got=%0b exp=1", o_err);
        end
        checks++;
        if (o_bit_count !== 32'd0) begin
            failures++;
            $display("FAIL clr_bitcnt got=%0d exp=0", o_bit_count);
        end
        checks++;
        if (o_err_count !== 32'd0) begin
            failures++;
            $display("FAIL clr_errcnt got=%0d exp=0", o_err_count);
        end
        checks++;
        if (o_lock !== 1'b1) begin
            failures++;
            $display("FAIL clr_lock got=%0b exp=1", o_lock);
        end
        for (int i = 0; i < 3; i++) begin
            gen(b);
            step(1'b1, b, 1'b0);
        end
        checks++;
        if (o_bit_count !== 32'd3) begin
            failures++;
            $display("FAIL post_clr_bitcnt got=%0d exp=3", o_bit_count);
        end
        i_reset = 1'b0;
        gen(b);
        step(1'b1, ~b, 1'b1);
        checks++;
        if (o_lock !== 1'b0 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid lock=%0b err=%0b exp=0/0", o_lock, o_err);
        end
        checks++;
        if (o_bit_count !== 32'd0 || o_err_count !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_cnt bit=%0d err=%0d exp=0/0",
                     o_bit_count, o_err_count);
        end
        i_reset = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        g        = 9'b110101010;
        i_reset  = 1'b0;
        i_valid  = 1'b0;
        i_bit    = 1'b0;
        i_clear  = 1'b0;
        test_reset();
        test_lock();
        test_single_error();
        test_loss();
        test_stuck0();
        test_gapped();
        test_clear_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs9_checker.md
PRBS9_CHECKER -- requirements
Module: prbs9_checker

Interface
REQ-001 Parameter LOCK_CNT, default 16: consecutive correct predictions needed to declare lock.
REQ-002 Parameter LOSS_THR, default 8: errors within one loss window that force loss of lock.
REQ-003 Parameter LOSS_WIN, default 64: loss-window length, in valid bits.
REQ-004 Parameter CNT_W, default 32: width of the statistics counters.
REQ-005 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-006 i_reset  input  1  synchronous, active-low reset.
REQ-007 i_valid  input  1  bit strobe; i_bit is sampled only when i_valid=1.
REQ-008 i_bit  input  1  received serial PRBS9 bit.
REQ-009 i_clear  input  1  synchronous clear of the statistics counters.
REQ-010 o_lock  output  1  high while in state LOCKED.
REQ-011 o_err  output  1  one-cycle pulse per mismatched bit while LOCKED.
REQ-012 o_bit_count  output  CNT_W  number of bits compared while LOCKED.
REQ-013 o_err_count  output  CNT_W  number of mismatches while LOCKED.

Function
REQ-014 Polynomial SHALL be x^9+x^5+1; predicted bit = sr[4]^sr[8], where sr[0] is the newest bit.
REQ-015 The FSM SHALL have three states: FILL, SEARCH and LOCKED.
REQ-016 In FILL, each valid bit SHALL shift into sr; after 9 valid bits the FSM SHALL go to SEARCH with the match counter at 0.
REQ-017 In SEARCH, each valid bit SHALL shift into sr and be compared with the prediction; a match increments the match counter, a mismatch clears it.
REQ-018 In SEARCH, an all-zero sr SHALL count as a mismatch, to prevent false lock on a stuck-at-0 input.
REQ-019 When the match counter reaches LOCK_CNT, the FSM SHALL enter LOCKED on the next edge.
REQ-020 Lock latency from a clean stream: o_lock SHALL rise on the edge after valid bit 9+LOCK_CNT is sampled.
REQ-021 In LOCKED, sr SHALL free-run by shifting in the predicted bit, not i_bit.
REQ-022 In LOCKED, each valid bit SHALL increment o_bit_count and the window bit counter.
REQ-023 In LOCKED, a mismatched bit SHALL additionally pulse o_err on the next edge (1-cycle latency) and increment o_err_count and the window error counter.
REQ-024 When the window error counter reaches LOSS_THR, the FSM SHALL go to FILL immediately, even mid-window; o_lock SHALL fall on that edge.
REQ-025 When the window bit counter reaches LOSS_WIN, both window counters SHALL clear.
REQ-026 When i_valid=0, no state, sr, counter or o_err change SHALL occur; o_err SHALL be 0.
REQ-027 i_clear SHALL have priority over a simultaneous count: both counters go to 0 and the coincident bit is not counted; the FSM, sr and o_err are unaffected.
REQ-028 Without the configuration macro, counters SHALL wrap modulo 2^CNT_W.

Reset
REQ-029 While i_reset=0: state=FILL, sr=0, match/window counters=0, o_lock=0, o_err=0, o_bit_count=0, o_err_count=0.
REQ-030 Reset applied mid-lock SHALL take effect on the next edge, and reset SHALL override i_valid and i_clear.

Configuration
REQ-031 Macro PRBS_CHK_SAT_EN defined: o_bit_count and o_err_count SHALL saturate at all-ones.
REQ-032 Macro PRBS_CHK_SAT_EN undefined: o_bit_count and o_err_count SHALL wrap to 0.

Structure
REQ-033 Package prbs_pkg SHALL hold the tap constants (8, 4), the seed constant 9'b110101010, the width constant 9 and the FSM state enum.
REQ-034 Sub-module prbs9_predict SHALL be the single combinational next-bit function, shared with the generator.

Verification
REQ-035 Lock: reset, then a clean generator stream from seed 110101010 with i_valid=1 every cycle -> o_lock rises after bit 25 and o_err_count stays 0 for 1000 bits.
REQ-036 Single error: after lock, invert locked bit 100 -> exactly one o_err pulse; o_err_count=1; o_bit_count=1000 after 1000 locked bits; o_lock stays 1.
REQ-037 Loss: after lock, invert 8 bits within 20 bits -> o_lock falls on the edge after the 8th error; relock occurs 25 valid bits later.
REQ-038 Stuck-at-0: 2000 zero bits -> o_lock never asserts.
REQ-039 Gapped valid (i_valid 1-of-3 cycles): clean stream -> lock after 25 valid bits; o_err never pulses.
REQ-040 i_clear coincident with an error, then reset mid-lock -> counters read 0 after the clear; on reset, all outputs are 0 on the next edge.
